// File: rtl/mod_counter.sv
// Loadable up/down counter with programmable modulus, wrap-or-saturate behaviour and a
// clock-enable prescaler. Wrap and TerminalCount allow direct cascading of instances.
module mod_counter #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MAX_COUNT = (1 << WIDTH) - 1,
  parameter bit          SATURATE  = 1'b0,
  parameter int unsigned PRESCALE  = 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] DataIn,
  input  logic             Load,
  input  logic             Enable,
  input  logic             Up,
  output logic [WIDTH-1:0] DataOut,
  output logic             TerminalCount,
  output logic             Wrap
);

  localparam int unsigned PcntW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] MaxVal  = WIDTH'(MAX_COUNT);
  localparam logic [PcntW-1:0] PcntTop = PcntW'(PRESCALE - 1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [PcntW-1:0] pcnt_q, pcnt_d;
  logic             wrap_q, wrap_d;
  logic             tick;
  logic             at_bound;

  assign tick     = Enable && (pcnt_q == PcntTop);
  assign at_bound = Up ? (cnt_q == MaxVal) : (cnt_q == '0);

  always_comb begin
    cnt_d  = cnt_q;
    pcnt_d = pcnt_q;
    wrap_d = 1'b0;
    if (Load) begin
      cnt_d  = (DataIn > MaxVal) ? MaxVal : DataIn;
      pcnt_d = '0;
    end else if (tick) begin
      pcnt_d = '0;
      wrap_d = at_bound;
      if (at_bound) begin
        // Saturating instances hold; wrapping ones jump to the opposite boundary.
        if (!SATURATE) begin
          cnt_d = Up ? '0 : MaxVal;
        end
      end else begin
        cnt_d = Up ? cnt_q + 1'b1 : cnt_q - 1'b1;
      end
    end else if (Enable) begin
      pcnt_d = pcnt_q + 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt_q  <= '0;
      pcnt_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pcnt_q <= pcnt_d;
      wrap_q <= wrap_d;
    end
  end

  assign DataOut       = cnt_q;
  assign Wrap          = wrap_q;
  assign TerminalCount = at_bound;

endmodule

// File: tb/tb_mod_counter.sv
// Directed bench for mod_counter: wrap, modulus/clamp, saturate, prescale, priority and
// a two-stage BCD cascade, each on its own parameterised instance.
module tb_mod_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // a: defaults, b: MAX_COUNT=9, c: saturating, d: PRESCALE=3, lo/hi: BCD cascade
  logic       a_rst, a_load, a_en, a_up, a_tc, a_wrap;
  logic [3:0] a_din, a_out;
  logic       b_rst, b_load, b_en, b_up, b_tc, b_wrap;
  logic [3:0] b_din, b_out;
  logic       c_rst, c_load, c_en, c_up, c_tc, c_wrap;
  logic [3:0] c_din, c_out;
  logic       d_rst, d_load, d_en, d_up, d_tc, d_wrap;
  logic [3:0] d_din, d_out;
  logic       casc_rst, casc_en, lo_tc, lo_wrap, hi_tc, hi_wrap, hi_en;
  logic [3:0] lo_out, hi_out;

  assign hi_en = lo_tc && casc_en;

  mod_counter u_a (
    .Clk(clk), .Reset(a_rst), .DataIn(a_din), .Load(a_load), .Enable(a_en), .Up(a_up),
    .DataOut(a_out), .TerminalCount(a_tc), .Wrap(a_wrap)
  );

  mod_counter #(.MAX_COUNT(9)) u_b (
    .Clk(clk), .Reset(b_rst), .DataIn(b_din), .Load(b_load), .Enable(b_en), .Up(b_up),
    .DataOut(b_out), .TerminalCount(b_tc), .Wrap(b_wrap)
  );

  mod_counter #(.SATURATE(1'b1)) u_c (
    .Clk(clk), .Reset(c_rst), .DataIn(c_din), .Load(c_load), .Enable(c_en), .Up(c_up),
    .DataOut(c_out), .TerminalCount(c_tc), .Wrap(c_wrap)
  );

  mod_counter #(.PRESCALE(3)) u_d (
    .Clk(clk), .Reset(d_rst), .DataIn(d_din), .Load(d_load), .Enable(d_en), .Up(d_up),
    .DataOut(d_out), .TerminalCount(d_tc), .Wrap(d_wrap)
  );

  mod_counter #(.MAX_COUNT(9)) u_lo (
    .Clk(clk), .Reset(casc_rst), .DataIn(4'd0), .Load(1'b0), .Enable(casc_en), .Up(1'b1),
    .DataOut(lo_out), .TerminalCount(lo_tc), .Wrap(lo_wrap)
  );

  mod_counter #(.MAX_COUNT(9)) u_hi (
    .Clk(clk), .Reset(casc_rst), .DataIn(4'd0), .Load(1'b0), .Enable(hi_en), .Up(1'b1),
    .DataOut(hi_out), .TerminalCount(hi_tc), .Wrap(hi_wrap)
  );

  initial begin
    int exp_v;
    int hi_wraps;
    int seq [6];
    seq = '{0, 0, 1, 1, 1, 2};

    {a_rst, b_rst, c_rst, d_rst, casc_rst} = '1;
    {a_load, b_load, c_load, d_load} = '0;
    {a_en, b_en, c_en, d_en, casc_en} = '0;
    {a_up, b_up, c_up, d_up} = '0;
    {a_din, b_din, c_din, d_din} = '0;
    step();
    {a_rst, b_rst, c_rst, d_rst, casc_rst} = '0;

    // Reset state
    check_eq("rst_out", a_out, 0);
    check_eq("rst_wrap", a_wrap, 0);
    check_eq("rst_tc_down", a_tc, 1);
    a_up = 1'b1;
    #1;
    check_eq("rst_tc_up", a_tc, 0);

    // Load 7 then count up through the 15 -> 0 wrap
    a_load = 1'b1; a_din = 4'd7;
    step();
    check_eq("a_load7", a_out, 7);
    a_load = 1'b0; a_en = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step();
      exp_v = (7 + i) % 16;
      check_eq("a_cnt", a_out, exp_v);
      check_eq("a_wrap", a_wrap, (exp_v == 0) ? 1 : 0);
      check_eq("a_tc", a_tc, (exp_v == 15) ? 1 : 0);
    end

    // Load beats a tick; reset beats load
    a_load = 1'b1; a_din = 4'd5;
    step();
    check_eq("a_load_vs_tick", a_out, 5);
    a_load = 1'b0;
    step();
    check_eq("a_after_load", a_out, 6);
    a_rst = 1'b1; a_load = 1'b1; a_din = 4'd9;
    step();
    check_eq("a_rst_vs_load", a_out, 0);
    check_eq("a_rst_wrap", a_wrap, 0);
    a_rst = 1'b0; a_load = 1'b0;

    // MAX_COUNT=9 counting down with wrap, then clamped load
    check_eq("b_tc_zero", b_tc, 1);
    b_en = 1'b1;
    step();
    check_eq("b_wrap_to9", b_out, 9);
    check_eq("b_wrap_pulse", b_wrap, 1);
    check_eq("b_tc9_down", b_tc, 0);
    step();
    check_eq("b_dn8", b_out, 8);
    check_eq("b_wrap_clear", b_wrap, 0);
    step();
    check_eq("b_dn7", b_out, 7);
    b_en = 1'b0; b_load = 1'b1; b_din = 4'd12;
    step();
    check_eq("b_clamp", b_out, 9);
    b_load = 1'b0; b_up = 1'b1;
    #1;
    check_eq("b_tc9_up", b_tc, 1);

    // Saturating at 15 and at 0
    c_load = 1'b1; c_din = 4'd14;
    step();
    check_eq("c_load14", c_out, 14);
    c_load = 1'b0; c_en = 1'b1; c_up = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      check_eq("c_sat_hi", c_out, 15);
      check_eq("c_sat_wrap", c_wrap, (i > 1) ? 1 : 0);
    end
    c_up = 1'b0;
    step();
    check_eq("c_dn14", c_out, 14);
    check_eq("c_dn_wrap", c_wrap, 0);
    step();
    check_eq("c_dn13", c_out, 13);
    c_load = 1'b1; c_din = 4'd0;
    step();
    c_load = 1'b0;
    step();
    check_eq("c_sat_lo", c_out, 0);
    check_eq("c_sat_lo_wrap", c_wrap, 1);
    check_eq("c_sat_lo_tc", c_tc, 1);

    // PRESCALE=3: steps every third enabled edge, pauses hold the prescaler
    d_up = 1'b1; d_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check_eq("d_pre", d_out, seq[i]);
    end
    step();
    check_eq("d_mid", d_out, 2);
    d_en = 1'b0;
    repeat (5) begin
      step();
      check_eq("d_hold", d_out, 2);
    end
    d_en = 1'b1;
    step();
    check_eq("d_resume1", d_out, 2);
    step();
    check_eq("d_resume2", d_out, 3);
    step();
    check_eq("d_pre_rst", d_out, 3);
    d_rst = 1'b1;
    step();
    check_eq("d_rst", d_out, 0);
    d_rst = 1'b0;
    step();
    check_eq("d_post_rst1", d_out, 0);
    step();
    check_eq("d_post_rst2", d_out, 0);
    step();
    check_eq("d_post_rst3", d_out, 1);
    step();
    step();
    d_load = 1'b1; d_din = 4'd4;
    step();
    check_eq("d_load_vs_tick", d_out, 4);
    d_load = 1'b0;
    step();
    check_eq("d_post_load1", d_out, 4);
    step();
    check_eq("d_post_load2", d_out, 4);
    step();
    check_eq("d_post_load3", d_out, 5);

    // BCD cascade: 100 enabled cycles go 01..99 then 00
    hi_wraps = 0;
    casc_en  = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      step();
      check_eq("bcd", 32'(hi_out) * 10 + 32'(lo_out), k % 100);
      if (hi_wrap) hi_wraps++;
    end
    check_eq("bcd_hi_wraps", hi_wraps, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
